// File: rtl/alsu_flag_unit.sv
// Flag generation for an ALSU: registered carry/zero/negative/overflow flags,
// a sticky carry, and a two-state chain tracker for multi-word zero detection.
module alsu_flag_unit #(
  parameter int               WIDTH   = 4,
  parameter int               SEL_W   = 5,
  parameter logic [SEL_W-1:0] ADD_SEL = 5'b00000,
  parameter logic [SEL_W-1:0] SUB_SEL = 5'b00001,
  parameter logic [SEL_W-1:0] INC_SEL = 5'b01110,
  parameter logic [SEL_W-1:0] DEC_SEL = 5'b01111
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Valid_In,
  input  logic [SEL_W-1:0] Sel,
  input  logic [WIDTH-1:0] Result,
  input  logic             Operand_A_Msb,
  input  logic             Operand_B_Msb,
  input  logic             Carry_Out_From_Adder,
  input  logic             Carry_Out_From_Subtractor,
  input  logic             Carry_Out_From_Incrementer,
  input  logic             Carry_Out_From_Decrementer,
  input  logic             Chain_In,
  input  logic             Sticky_En,
  input  logic             Flag_Clear,
  output logic             Carry_Out,
  output logic             Zero_Flag,
  output logic             Negative_Flag,
  output logic             Overflow_Flag,
  output logic             Sticky_Carry,
  output logic             Flags_Valid,
  output logic             Chain_Active
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CHAIN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic w_carry;
  logic w_ovf;
  logic w_res_msb;
  logic w_res_zero;
  logic w_zero_next;
  logic w_update;

  logic r_carry;
  logic r_zero;
  logic r_neg;
  logic r_ovf;
  logic r_sticky;
  logic r_flags_valid;

  assign w_res_msb  = Result[WIDTH-1];
  assign w_res_zero = (Result == '0);
  assign w_update   = Valid_In & ~Flag_Clear;

  // Opcode-dependent carry source and signed-overflow rule
  always_comb begin
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (Sel)
      ADD_SEL: begin
        w_carry = Carry_Out_From_Adder;
        w_ovf   = (Operand_A_Msb == Operand_B_Msb) & (w_res_msb != Operand_A_Msb);
      end
      SUB_SEL: begin
        w_carry = Carry_Out_From_Subtractor;
        w_ovf   = (Operand_A_Msb != Operand_B_Msb) & (w_res_msb != Operand_A_Msb);
      end
      INC_SEL: begin
        w_carry = Carry_Out_From_Incrementer;
        w_ovf   = ~Operand_A_Msb & w_res_msb;
      end
      DEC_SEL: begin
        w_carry = Carry_Out_From_Decrementer;
        w_ovf   = Operand_A_Msb & ~w_res_msb;
      end
      default: begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  // Inside a chain the zero flag accumulates over every word seen so far
  assign w_zero_next = (r_state == S_CHAIN) ? (r_zero & w_res_zero) : w_res_zero;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (Flag_Clear) begin
      w_state_next = S_IDLE;
    end else if (Valid_In) begin
      case (r_state)
        S_IDLE:  if (Chain_In)  w_state_next = S_CHAIN;
        S_CHAIN: if (!Chain_In) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_carry       <= 1'b0;
      r_zero        <= 1'b0;
      r_neg         <= 1'b0;
      r_ovf         <= 1'b0;
      r_sticky      <= 1'b0;
      r_flags_valid <= 1'b0;
    end else if (Flag_Clear) begin
      r_carry       <= 1'b0;
      r_zero        <= 1'b0;
      r_neg         <= 1'b0;
      r_ovf         <= 1'b0;
      r_sticky      <= 1'b0;
      r_flags_valid <= 1'b0;
    end else begin
      r_flags_valid <= Valid_In;
      if (w_update) begin
        r_carry  <= w_carry;
        r_zero   <= w_zero_next;
        r_neg    <= w_res_msb;
        r_ovf    <= w_ovf;
        r_sticky <= r_sticky | (Sticky_En & w_carry);
      end
    end
  end

  assign Carry_Out     = r_carry;
  assign Zero_Flag     = r_zero;
  assign Negative_Flag = r_neg;
  assign Overflow_Flag = r_ovf;
  assign Sticky_Carry  = r_sticky;
  assign Flags_Valid   = r_flags_valid;
  assign Chain_Active  = (r_state == S_CHAIN);

endmodule
